// File: rtl/adc_regs_pkg.sv
// Shared register map, response codes and FSM state types for the multi-channel
// ADC AXI4-Lite register block.
package adc_regs_pkg;

    localparam int ADDR_CTRL   = 'h00;
    localparam int ADDR_STATUS = 'h04;
    localparam int ADDR_MASK   = 'h08;
    localparam int ADDR_CNT    = 'h0C;
    localparam int ADDR_CH0    = 'h10;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_IE  = 1;
    localparam int CTRL_CLR = 2;

    localparam int STATUS_OVR_LSB = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/adc_capture_bank.sv
// Per-channel sample registers with NEW/OVR tracking and the accepted-sample counter.
// Priority: CLR > capture set > read-clear / W1C.
module adc_capture_bank #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 12,
    parameter int CH_W     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [NUM_CH-1:0]                ch_mask,
    input  logic                             adc_valid,
    input  logic [CH_W-1:0]                  adc_ch,
    input  logic [SAMPLE_W-1:0]              adc_data,
    input  logic                             clr,
    input  logic                             rd_clr,
    input  logic [CH_W-1:0]                  rd_ch,
    input  logic [NUM_CH-1:0]                w1c_new,
    input  logic [NUM_CH-1:0]                w1c_ovr,
    output logic [NUM_CH-1:0][SAMPLE_W-1:0]  samples,
    output logic [NUM_CH-1:0]                new_flags,
    output logic [NUM_CH-1:0]                ovr_flags,
    output logic [31:0]                      sample_cnt
);

    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] rd_hit;
    logic              accept;

    // NOTE: every output of this block gets a default before the loop so no path
    // leaves a bit unassigned, which would otherwise infer a latch.
    always_comb begin
        hit    = '0;
        rd_hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            // Out-of-range channel indices never match and are silently dropped.
            if (adc_valid && en && ch_mask[k] && (adc_ch == CH_W'(k)))
                hit[k] = 1'b1;
            if (rd_clr && (rd_ch == CH_W'(k)))
                rd_hit[k] = 1'b1;
        end
    end

    assign accept = |hit;

    // NOTE: the sample registers are software-visible state and so carry a reset,
    // unlike a bulk RAM whose contents would be left uninitialised.
    // NOTE: sequential state uses non-blocking assignments so every register sees
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samples    <= '0;
            new_flags  <= '0;
            ovr_flags  <= '0;
            sample_cnt <= '0;
        end else if (clr) begin
            samples    <= '0;
            new_flags  <= '0;
            ovr_flags  <= '0;
            sample_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (hit[k])
                    samples[k] <= adc_data;
            end
            new_flags <= (new_flags & ~(w1c_new | rd_hit)) | hit;
            ovr_flags <= (ovr_flags & ~w1c_ovr) | (hit & new_flags);
            if (accept)
                sample_cnt <= sample_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/adc_axil_mc_regs.sv
// AXI4-Lite slave for the multi-channel ADC: write/read FSMs, address decode,
// control registers and the registered read-data mux around adc_capture_bank.
module adc_axil_mc_regs
    import adc_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int NUM_CH             = 4,
    parameter int SAMPLE_W           = 12,
    parameter int SIGN_EXTEND        = 0,
    localparam int CH_W              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              adc_valid,
    output logic                              adc_ready,
    input  logic [CH_W-1:0]                   adc_ch,
    input  logic [SAMPLE_W-1:0]               adc_data,
    output logic                              irq
);

    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int AW        = C_S_AXI_ADDR_WIDTH;
    localparam int STRB_W    = DW / 8;
    localparam int LAST_ADDR = ADDR_CH0 + 4 * (NUM_CH - 1);

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic              ctrl_en, ctrl_ie, clr_pulse;
    logic [NUM_CH-1:0] ch_mask;
    logic [AW-1:0]     aw_addr_q;
    logic [DW-1:0]     w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [DW-1:0]     rdata_q;

    logic              aw_hs, w_hs, ar_hs, wr_commit;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data, wr_mask, wr_bits, rd_mux;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_ok, rd_ok, wr_is_status, rd_is_ch;
    logic [CH_W-1:0]   rd_ch;

    logic [NUM_CH-1:0][SAMPLE_W-1:0] samples;
    logic [NUM_CH-1:0]               new_flags, ovr_flags, w1c_new, w1c_ovr;
    logic [31:0]                     sample_cnt;
    logic                            unused_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a[1:0] == 2'b00) && (int'(a) <= LAST_ADDR);
    endfunction

    function automatic logic [DW-1:0] extend(input logic [SAMPLE_W-1:0] s);
        if (SIGN_EXTEND != 0)
            return DW'($signed(s));
        return DW'(s);
    endfunction

    // Readies are held low while reset is asserted so every output reads 0.
    assign S_AXI_AWREADY = !ARESET && (wr_state == W_IDLE || wr_state == W_HAVE_W);
    assign S_AXI_WREADY  = !ARESET && (wr_state == W_IDLE || wr_state == W_HAVE_AW);
    assign S_AXI_BVALID  = (wr_state == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = !ARESET && (rd_state == R_IDLE);
    assign S_AXI_RVALID  = (rd_state == R_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    assign adc_ready = ctrl_en;
    assign irq       = ctrl_ie && |(new_flags & ch_mask);
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_bits};

    // ---------------------------------------------------------------- write path
    always_comb begin
        wr_next   = wr_state;
        wr_commit = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_commit = 1'b1;
                    wr_next   = W_RESP;
                end else if (aw_hs) begin
                    wr_next = W_HAVE_AW;
                end else if (w_hs) begin
                    wr_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: if (w_hs) begin
                wr_commit = 1'b1;
                wr_next   = W_RESP;
            end
            W_HAVE_W: if (aw_hs) begin
                wr_commit = 1'b1;
                wr_next   = W_RESP;
            end
            W_RESP: if (S_AXI_BREADY) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    // The commit uses whichever half arrived earlier from its holding register.
    always_comb begin
        wr_addr = (wr_state == W_HAVE_AW) ? aw_addr_q : S_AXI_AWADDR;
        wr_data = (wr_state == W_HAVE_W)  ? w_data_q  : S_AXI_WDATA;
        wr_strb = (wr_state == W_HAVE_W)  ? w_strb_q  : S_AXI_WSTRB;
        wr_mask = '0;
        for (int b = 0; b < STRB_W; b++)
            wr_mask[8*b +: 8] = {8{wr_strb[b]}};
        wr_bits      = wr_data & wr_mask;
        wr_ok        = addr_ok(wr_addr);
        wr_is_status = wr_commit && wr_ok && (int'(wr_addr) == ADDR_STATUS);
        w1c_new      = wr_is_status ? wr_bits[NUM_CH-1:0] : '0;
        w1c_ovr      = wr_is_status ? wr_bits[STATUS_OVR_LSB +: NUM_CH] : '0;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state  <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            ctrl_en   <= 1'b0;
            ctrl_ie   <= 1'b0;
            clr_pulse <= 1'b0;
            ch_mask   <= '1;
        end else begin
            wr_state  <= wr_next;
            clr_pulse <= 1'b0;
            if (aw_hs)
                aw_addr_q <= S_AXI_AWADDR;
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (wr_commit) begin
                bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok) begin
                    case (int'(wr_addr))
                        ADDR_CTRL: begin
                            ctrl_en   <= (ctrl_en & ~wr_mask[CTRL_EN]) | wr_bits[CTRL_EN];
                            ctrl_ie   <= (ctrl_ie & ~wr_mask[CTRL_IE]) | wr_bits[CTRL_IE];
                            clr_pulse <= wr_bits[CTRL_CLR];
                        end
                        ADDR_MASK:
                            ch_mask <= (ch_mask & ~wr_mask[NUM_CH-1:0]) | wr_bits[NUM_CH-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // ----------------------------------------------------------------- read path
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_next = R_RESP;
            R_RESP:  if (S_AXI_RREADY) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        rd_ok    = addr_ok(S_AXI_ARADDR);
        rd_ch    = CH_W'((int'(S_AXI_ARADDR) - ADDR_CH0) >> 2);
        rd_is_ch = rd_ok && (int'(S_AXI_ARADDR) >= ADDR_CH0);
        rd_mux   = '0;
        if (rd_ok) begin
            case (int'(S_AXI_ARADDR))
                ADDR_CTRL: begin
                    rd_mux[CTRL_EN] = ctrl_en;
                    rd_mux[CTRL_IE] = ctrl_ie;
                end
                ADDR_STATUS: begin
                    rd_mux[NUM_CH-1:0]                = new_flags;
                    rd_mux[STATUS_OVR_LSB +: NUM_CH] = ovr_flags;
                end
                ADDR_MASK: rd_mux[NUM_CH-1:0] = ch_mask;
                ADDR_CNT:  rd_mux = DW'(sample_cnt);
                default:   rd_mux = extend(samples[rd_ch]);
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                rdata_q <= rd_mux;
                rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    adc_capture_bank #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .CH_W     (CH_W)
    ) u_bank (
        .clk        (ACLK),
        .rst        (ARESET),
        .en         (ctrl_en),
        .ch_mask    (ch_mask),
        .adc_valid  (adc_valid),
        .adc_ch     (adc_ch),
        .adc_data   (adc_data),
        .clr        (clr_pulse),
        .rd_clr     (ar_hs && rd_is_ch),
        .rd_ch      (rd_ch),
        .w1c_new    (w1c_new),
        .w1c_ovr    (w1c_ovr),
        .samples    (samples),
        .new_flags  (new_flags),
        .ovr_flags  (ovr_flags),
        .sample_cnt (sample_cnt)
    );

endmodule

// File: tb/tb_adc_axil_mc_regs.sv
// Directed self-checking bench for adc_axil_mc_regs (NUM_CH=4, SAMPLE_W=12, zero-extend).
module tb_adc_axil_mc_regs;

    localparam int TMO = 50;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [6:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [6:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        adc_valid = 1'b0;
    logic        adc_ready;
    logic [1:0]  adc_ch = '0;
    logic [11:0] adc_data = '0;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    int b_count  = 0;

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK)
        if (S_AXI_BVALID && S_AXI_BREADY) b_count <= b_count + 1;

    adc_axil_mc_regs dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .adc_valid     (adc_valid),
        .adc_ready     (adc_ready),
        .adc_ch        (adc_ch),
        .adc_data      (adc_data),
        .irq           (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic send_aw(input logic [6:0] addr);
        int n = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        while (!S_AXI_AWREADY && n < TMO) begin @(negedge ACLK); n++; end
        if (!S_AXI_AWREADY) check("aw_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        while (!S_AXI_WREADY && n < TMO) begin @(negedge ACLK); n++; end
        if (!S_AXI_WREADY) check("w_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n = 0;
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        while (!S_AXI_BVALID && n < TMO) begin @(negedge ACLK); n++; end
        if (!S_AXI_BVALID) check("b_timeout", 32'd0, 32'd1);
        resp = S_AXI_BRESP;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        fork
            send_aw(addr);
            send_w(data, strb);
        join
        wait_b(resp);
    endtask

    task automatic send_ar(input logic [6:0] addr);
        int n = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        while (!S_AXI_ARREADY && n < TMO) begin @(negedge ACLK); n++; end
        if (!S_AXI_ARREADY) check("ar_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic recv_r(output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        while (!S_AXI_RVALID && n < TMO) begin @(negedge ACLK); n++; end
        if (!S_AXI_RVALID) check("r_timeout", 32'd0, 32'd1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [6:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        send_ar(addr);
        recv_r(d, r);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_resp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic wr_check(input string tag, input logic [6:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_write(addr, data, strb, r);
        check({tag, "_bresp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic capture(input logic [1:0] ch, input logic [11:0] d);
        adc_valid = 1'b1;
        adc_ch    = ch;
        adc_data  = d;
        @(posedge ACLK); #1;
        adc_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        int          b0;

        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check("rst_irq",     32'(irq),           32'd0);
        check("rst_ready",   32'(adc_ready),     32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;

        rd_check("rst_ctrl",   7'h00, 32'h0, 2'b00);
        rd_check("rst_status", 7'h04, 32'h0, 2'b00);
        rd_check("rst_mask",   7'h08, 32'hF, 2'b00);
        rd_check("rst_cnt",    7'h0C, 32'h0, 2'b00);

        // Simultaneous AW/W write then read-back.
        wr_check("ctrl3", 7'h00, 32'h3, 4'hF, 2'b00);
        rd_check("ctrl3", 7'h00, 32'h3, 2'b00);
        check("adc_ready_en", 32'(adc_ready), 32'd1);

        // AW three cycles ahead of W.
        b0 = b_count;
        send_aw(7'h00);
        repeat (3) @(posedge ACLK); #1;
        check("aw_first_no_b", 32'(S_AXI_BVALID), 32'd0);
        send_w(32'h1, 4'hF);
        wait_b(r);
        check("aw_first_bresp", 32'(r), 32'd0);
        check("aw_first_bcount", 32'(b_count - b0), 32'd1);
        rd_check("aw_first_ctrl", 7'h00, 32'h1, 2'b00);

        // W three cycles ahead of AW.
        b0 = b_count;
        send_w(32'h3, 4'hF);
        repeat (3) @(posedge ACLK); #1;
        check("w_first_no_b", 32'(S_AXI_BVALID), 32'd0);
        send_aw(7'h00);
        wait_b(r);
        check("w_first_bcount", 32'(b_count - b0), 32'd1);
        rd_check("w_first_ctrl", 7'h00, 32'h3, 2'b00);

        // Overrun on ch1, then read-clear of NEW[1].
        capture(2'd1, 12'hABC);
        capture(2'd1, 12'h123);
        rd_check("ch1",        7'h14, 32'h0000_0123, 2'b00);
        rd_check("ovr_status", 7'h04, 32'h0002_0000, 2'b00);
        rd_check("cnt2",       7'h0C, 32'd2,         2'b00);
        capture(2'd3, 12'hF00);
        rd_check("ch3_zext",   7'h1C, 32'h0000_0F00, 2'b00);

        // CLR zeroes samples, flags and counter and reads back as 0.
        wr_check("clr", 7'h00, 32'h7, 4'hF, 2'b00);
        rd_check("clr_ctrl",   7'h00, 32'h3, 2'b00);
        rd_check("clr_cnt",    7'h0C, 32'h0, 2'b00);
        rd_check("clr_status", 7'h04, 32'h0, 2'b00);
        rd_check("clr_ch1",    7'h14, 32'h0, 2'b00);

        // Capture on ch0 in the same cycle as the AR handshake on CH0.
        capture(2'd0, 12'h005);
        S_AXI_ARADDR  = 7'h10;
        S_AXI_ARVALID = 1'b1;
        adc_valid     = 1'b1;
        adc_ch        = 2'd0;
        adc_data      = 12'h006;
        @(negedge ACLK);
        check("same_arready", 32'(S_AXI_ARREADY), 32'd1);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        adc_valid     = 1'b0;
        recv_r(d, r);
        check("same_rdata", d, 32'h5);
        rd_check("same_status", 7'h04, 32'h0001_0001, 2'b00);
        rd_check("same_ch0",    7'h10, 32'h6,         2'b00);
        rd_check("ch0_rdclr",   7'h04, 32'h0001_0000, 2'b00);
        wr_check("w1c_ovr", 7'h04, 32'h0001_0000, 4'hF, 2'b00);
        rd_check("w1c_ovr_status", 7'h04, 32'h0, 2'b00);

        // Invalid addresses and RO writes.
        rd_check("bad_hi",  7'h20, 32'h0, 2'b10);
        rd_check("bad_una", 7'h02, 32'h0, 2'b10);
        wr_check("bad_wr_una", 7'h01, 32'h0, 4'hF, 2'b10);
        wr_check("bad_wr_hi",  7'h20, 32'h0, 4'hF, 2'b10);
        rd_check("bad_wr_ctrl", 7'h00, 32'h3, 2'b00);
        wr_check("ro_cnt", 7'h0C, 32'h0, 4'hF, 2'b00);
        rd_check("ro_cnt", 7'h0C, 32'd2, 2'b00);

        // Masking, strobes and irq.
        wr_check("mask1", 7'h08, 32'h1, 4'hF, 2'b00);
        wr_check("mask_strb", 7'h08, 32'h0, 4'h2, 2'b00);
        rd_check("mask1", 7'h08, 32'h1, 2'b00);
        capture(2'd2, 12'h777);
        check("masked_irq", 32'(irq), 32'd0);
        capture(2'd0, 12'h009);
        check("irq_set", 32'(irq), 32'd1);
        rd_check("mask_status", 7'h04, 32'h1, 2'b00);
        rd_check("mask_cnt",    7'h0C, 32'd3, 2'b00);
        wr_check("w1c_new", 7'h04, 32'h1, 4'hF, 2'b00);
        check("irq_clr", 32'(irq), 32'd0);
        rd_check("ch2_dropped", 7'h18, 32'h0, 2'b00);

        // Reset while the response is pending.
        fork
            send_aw(7'h00);
            send_w(32'h2, 4'hF);
        join
        check("pre_rst_bvalid", 32'(S_AXI_BVALID), 32'd1);
        ARESET = 1'b1;
        #1;
        check("mid_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        check("post_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("post_rst_irq",    32'(irq),          32'd0);
        @(posedge ACLK); #1;
        rd_check("post_rst_ctrl",   7'h00, 32'h0, 2'b00);
        rd_check("post_rst_mask",   7'h08, 32'hF, 2'b00);
        rd_check("post_rst_cnt",    7'h0C, 32'h0, 2'b00);
        rd_check("post_rst_status", 7'h04, 32'h0, 2'b00);
        rd_check("post_rst_ch0",    7'h10, 32'h0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
